// File: rtl/io_port_if.sv
// MCU I/O bus: strobe, port ID, write data out of the MCU and read data back into it.
interface io_port_if #(
    parameter int DATA_W = 8
);
    logic              io_strb;
    logic [7:0]        port_id;
    logic [DATA_W-1:0] out_port;
    logic [DATA_W-1:0] in_port;

    modport master (
        output io_strb,
        output port_id,
        output out_port,
        input  in_port
    );

    modport slave (
        input  io_strb,
        input  port_id,
        input  out_port,
        output in_port
    );
endinterface

// File: rtl/io_port_ctrl.sv
// MCU I/O port controller: output registers, VGA framebuffer write port, input mux and a pending interrupt.
// Defining VGA_AUTOINC_EN advances the framebuffer address by one after every pixel write.
module io_port_ctrl #(
    parameter int         DATA_W     = 8,
    parameter int         NUM_OUT    = 4,
    parameter logic [7:0] OUT_BASE   = 8'h40,
    parameter int         NUM_IN     = 2,
    parameter logic [7:0] IN_BASE    = 8'h20,
    parameter int         VGA_AW     = 13,
    parameter logic [7:0] VGA_BASE   = 8'h90,
    parameter logic [7:0] INT_CLR_ID = 8'hF0
) (
    input  logic                      clk,
    input  logic                      rst,
    io_port_if.slave                  bus,
    input  logic [NUM_IN*DATA_W-1:0]  in_data,
    output logic [NUM_OUT*DATA_W-1:0] out_regs,
    output logic [VGA_AW-1:0]         vga_wa,
    output logic [DATA_W-1:0]         vga_wd,
    output logic                      vga_we,
    input  logic [DATA_W-1:0]         vga_rd,
    input  logic                      int_src,
    output logic                      int_r
);

    logic                strb_q,    strb_d;
    logic                armed_q,   armed_d;
    logic                int_src_q, int_src_d;
    logic                pend_q,    pend_d;
    logic                vga_we_q,  vga_we_d;
    logic [VGA_AW-1:0]   vga_wa_q,  vga_wa_d;
    logic [DATA_W-1:0]   vga_wd_q,  vga_wd_d;
    logic [DATA_W-1:0]   out_q [NUM_OUT];
    logic [DATA_W-1:0]   out_d [NUM_OUT];

    logic [8:0]          pid9_s;
    logic [7:0]          out_off_s;
    logic [7:0]          in_off_s;
    logic                hit_out_s;
    logic                hit_in_s;
    logic                hit_vga_s;
    logic                wr_evt_s;
    logic                wr_out_s;
    logic                wr_haddr_s;
    logic                wr_laddr_s;
    logic                wr_color_s;
    logic                wr_intclr_s;
    logic                int_set_s;
    logic [DATA_W-1:0]   in_port_s;

    // Address decode with output registers taking priority over VGA, and VGA over the interrupt clear.
    always_comb begin
        pid9_s      = {1'b0, bus.port_id};
        out_off_s   = bus.port_id - OUT_BASE;
        in_off_s    = bus.port_id - IN_BASE;
        hit_out_s   = (pid9_s >= {1'b0, OUT_BASE}) &&
                      (pid9_s < ({1'b0, OUT_BASE} + 9'(NUM_OUT)));
        hit_in_s    = (pid9_s >= {1'b0, IN_BASE}) &&
                      (pid9_s < ({1'b0, IN_BASE} + 9'(NUM_IN)));
        hit_vga_s   = !hit_out_s &&
                      (pid9_s >= {1'b0, VGA_BASE}) &&
                      (pid9_s < ({1'b0, VGA_BASE} + 9'd4));
        // An armed flag blocks a strobe that was already high when reset released.
        wr_evt_s    = bus.io_strb && !strb_q && armed_q;
        wr_out_s    = wr_evt_s && hit_out_s;
        wr_haddr_s  = wr_evt_s && hit_vga_s && (bus.port_id == VGA_BASE);
        wr_laddr_s  = wr_evt_s && hit_vga_s && (bus.port_id == (VGA_BASE + 8'd1));
        wr_color_s  = wr_evt_s && hit_vga_s && (bus.port_id == (VGA_BASE + 8'd2));
        wr_intclr_s = wr_evt_s && !hit_out_s && !hit_vga_s && (bus.port_id == INT_CLR_ID);
        int_set_s   = int_src && !int_src_q;
    end

    // Next-state for strobe/interrupt history, pending flag and VGA write port.
    always_comb begin
        strb_d    = bus.io_strb;
        armed_d   = armed_q || !bus.io_strb;
        int_src_d = int_src;
        pend_d    = int_set_s || (pend_q && !wr_intclr_s);
        vga_we_d  = wr_color_s;
        vga_wd_d  = wr_color_s ? bus.out_port : vga_wd_q;
        vga_wa_d  = vga_wa_q;
        if (wr_haddr_s) begin
            vga_wa_d[VGA_AW-1:8] = bus.out_port[VGA_AW-9:0];
        end else if (wr_laddr_s) begin
            vga_wa_d[7:0] = bus.out_port[7:0];
        end else begin
`ifdef VGA_AUTOINC_EN
            if (vga_we_q) begin
                vga_wa_d = vga_wa_q + VGA_AW'(1);
            end else begin
                vga_wa_d = vga_wa_q;
            end
`else
            vga_wa_d = vga_wa_q;
`endif
        end
    end

    // Next-state for the general output registers.
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            out_d[k] = (wr_out_s && (out_off_s == 8'(k))) ? bus.out_port : out_q[k];
        end
    end

    // Read-data mux back to the MCU.
    always_comb begin
        in_port_s = {DATA_W{1'b0}};
        if (hit_in_s) begin
            for (int k = 0; k < NUM_IN; k++) begin
                in_port_s = in_port_s |
                            ({DATA_W{in_off_s == 8'(k)}} & in_data[k*DATA_W +: DATA_W]);
            end
        end else if (bus.port_id == (VGA_BASE + 8'd3)) begin
            in_port_s = vga_rd;
        end else if (bus.port_id == INT_CLR_ID) begin
            in_port_s = {{(DATA_W-1){1'b0}}, pend_q};
        end else begin
            in_port_s = {DATA_W{1'b0}};
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            strb_q    <= 1'b0;
            armed_q   <= 1'b0;
            int_src_q <= 1'b0;
            pend_q    <= 1'b0;
            vga_we_q  <= 1'b0;
            vga_wa_q  <= {VGA_AW{1'b0}};
            vga_wd_q  <= {DATA_W{1'b0}};
            for (int k = 0; k < NUM_OUT; k++) begin
                out_q[k] <= {DATA_W{1'b0}};
            end
        end else begin
            strb_q    <= strb_d;
            armed_q   <= armed_d;
            int_src_q <= int_src_d;
            pend_q    <= pend_d;
            vga_we_q  <= vga_we_d;
            vga_wa_q  <= vga_wa_d;
            vga_wd_q  <= vga_wd_d;
            for (int k = 0; k < NUM_OUT; k++) begin
                out_q[k] <= out_d[k];
            end
        end
    end

    // Pack registered state onto the output ports.
    always_comb begin
        for (int k = 0; k < NUM_OUT; k++) begin
            out_regs[k*DATA_W +: DATA_W] = out_q[k];
        end
    end

    assign bus.in_port = in_port_s;
    assign vga_wa      = vga_wa_q;
    assign vga_wd      = vga_wd_q;
    assign vga_we      = vga_we_q;
    assign int_r       = pend_q;

endmodule

// File: tb/tb_io_port_ctrl.sv
// Directed-vector bench for io_port_ctrl; expectations adapt to VGA_AUTOINC_EN when it is defined.
module tb_io_port_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] in_data;
    logic [31:0] out_regs;
    logic [12:0] vga_wa;
    logic [7:0]  vga_wd;
    logic        vga_we;
    logic [7:0]  vga_rd;
    logic        int_src;
    logic        int_r;
    int          checks;
    int          failures;

    io_port_if #(.DATA_W(8)) bus ();

    io_port_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .in_data  (in_data),
        .out_regs (out_regs),
        .vga_wa   (vga_wa),
        .vga_wd   (vga_wd),
        .vga_we   (vga_we),
        .vga_rd   (vga_rd),
        .int_src  (int_src),
        .int_r    (int_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] id, input logic [7:0] d, input int hold);
        @(negedge clk);
        bus.port_id  = id;
        bus.out_port = d;
        bus.io_strb  = 1'b1;
        repeat (hold) @(negedge clk);
        bus.io_strb  = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.io_strb  = 1'b0;
        bus.port_id  = 8'h00;
        bus.out_port = 8'h00;
        in_data      = 16'h0000;
        vga_rd       = 8'h00;
        int_src      = 1'b0;

        @(negedge clk);
        check_eq("rst_out",  out_regs, 32'h0);
        check_eq("rst_wa",   {19'h0, vga_wa}, 32'h0);
        check_eq("rst_wd",   {24'h0, vga_wd}, 32'h0);
        check_eq("rst_we",   {31'h0, vga_we}, 32'h0);
        check_eq("rst_int",  {31'h0, int_r}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Held strobe: one write, later data changes ignored
        bus.port_id  = 8'h41;
        bus.out_port = 8'hA5;
        bus.io_strb  = 1'b1;
        @(negedge clk);
        check_eq("o1_first", out_regs, 32'h0000A500);
        bus.out_port = 8'h11;
        repeat (3) @(negedge clk);
        check_eq("o1_held", out_regs, 32'h0000A500);
        bus.io_strb = 1'b0;
        @(negedge clk);

        bus_write(8'h40, 8'h12, 1);
        bus_write(8'h43, 8'h34, 2);
        check_eq("o_all", out_regs, 32'h3400A512);
        bus_write(8'h44, 8'hFF, 1);
        check_eq("o_range", out_regs, 32'h3400A512);
        bus_write(8'h77, 8'hFF, 1);
        check_eq("ign_out", out_regs, 32'h3400A512);
        check_eq("ign_wa",  {19'h0, vga_wa}, 32'h0);
        check_eq("ign_wd",  {24'h0, vga_wd}, 32'h0);
        check_eq("ign_int", {31'h0, int_r}, 32'h0);

        // VGA address halves, high half masked to 5 bits
        bus_write(8'h90, 8'hE2, 1);
        bus_write(8'h91, 8'h34, 1);
        check_eq("wa_0234", {19'h0, vga_wa}, 32'h0234);
        bus_write(8'h90, 8'h1F, 1);
        bus_write(8'h91, 8'hFF, 1);
        check_eq("wa_1fff", {19'h0, vga_wa}, 32'h1FFF);
        check_eq("we_idle", {31'h0, vga_we}, 32'h0);

        @(negedge clk);
        bus.port_id  = 8'h92;
        bus.out_port = 8'h3C;
        bus.io_strb  = 1'b1;
        @(negedge clk);
        check_eq("we_pulse", {31'h0, vga_we}, 32'h1);
        check_eq("wd_color", {24'h0, vga_wd}, 32'h3C);
        check_eq("wa_during", {19'h0, vga_wa}, 32'h1FFF);
        @(negedge clk);
        check_eq("we_drop", {31'h0, vga_we}, 32'h0);
`ifdef VGA_AUTOINC_EN
        check_eq("wa_after", {19'h0, vga_wa}, 32'h0000);
`else
        check_eq("wa_after", {19'h0, vga_wa}, 32'h1FFF);
`endif
        @(negedge clk);
        check_eq("we_held", {31'h0, vga_we}, 32'h0);
        bus.io_strb = 1'b0;
        @(negedge clk);
        check_eq("o_after_vga", out_regs, 32'h3400A512);

        // Combinational read mux
        in_data     = 16'h5A00;
        vga_rd      = 8'hE1;
        bus.port_id = 8'h21; #1;
        check_eq("rd_ch1", {24'h0, bus.in_port}, 32'h5A);
        bus.port_id = 8'h20; #1;
        check_eq("rd_ch0", {24'h0, bus.in_port}, 32'h00);
        bus.port_id = 8'h93; #1;
        check_eq("rd_vga", {24'h0, bus.in_port}, 32'hE1);
        bus.port_id = 8'h77; #1;
        check_eq("rd_none", {24'h0, bus.in_port}, 32'h00);
        bus.port_id = 8'hF0; #1;
        check_eq("rd_int0", {24'h0, bus.in_port}, 32'h00);

        // Interrupt set, clear, and set winning over clear
        @(negedge clk);
        int_src = 1'b1;
        @(negedge clk);
        check_eq("int_set", {31'h0, int_r}, 32'h1);
        bus.port_id = 8'hF0; #1;
        check_eq("rd_int1", {24'h0, bus.in_port}, 32'h01);
        bus_write(8'hF0, 8'h00, 1);
        check_eq("int_clr", {31'h0, int_r}, 32'h0);
        repeat (2) @(negedge clk);
        check_eq("int_level", {31'h0, int_r}, 32'h0);
        int_src = 1'b0;
        @(negedge clk);
        bus.port_id = 8'hF0;
        bus.io_strb = 1'b1;
        int_src     = 1'b1;
        @(negedge clk);
        check_eq("int_setclr", {31'h0, int_r}, 32'h1);
        bus.io_strb = 1'b0;
        int_src     = 1'b0;
        @(negedge clk);

        // Reset during a VGA write pulse, strobe held through release
        @(negedge clk);
        bus.port_id  = 8'h92;
        bus.out_port = 8'h5C;
        bus.io_strb  = 1'b1;
        @(negedge clk);
        check_eq("rst_pre_we", {31'h0, vga_we}, 32'h1);
        #1 rst = 1'b1;
        #1;
        check_eq("arst_we",  {31'h0, vga_we}, 32'h0);
        check_eq("arst_out", out_regs, 32'h0);
        check_eq("arst_wa",  {19'h0, vga_wa}, 32'h0);
        check_eq("arst_wd",  {24'h0, vga_wd}, 32'h0);
        check_eq("arst_int", {31'h0, int_r}, 32'h0);
        bus.port_id  = 8'h41;
        bus.out_port = 8'hEE;
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("held_out", out_regs, 32'h0);
        check_eq("held_we",  {31'h0, vga_we}, 32'h0);
        bus.io_strb = 1'b0;
        @(negedge clk);
        bus_write(8'h41, 8'h77, 1);
        check_eq("post_rst_wr", out_regs, 32'h00007700);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/io_port_ctrl.md
IO_PORT_CTRL -- requirements
Module: io_port_ctrl

Interface
REQ-001 Parameter DATA_W, 8, I/O data width.
REQ-002 Parameter NUM_OUT, 4, number of general output registers, legal 1..16.
REQ-003 Parameter OUT_BASE, 8'h40, port ID of output register 0; register k sits at OUT_BASE+k.
REQ-004 Parameter NUM_IN, 2, number of input channels, legal 1..16.
REQ-005 Parameter IN_BASE, 8'h20, port ID of input channel 0; channel k sits at IN_BASE+k.
REQ-006 Parameter VGA_AW, 13, framebuffer address width, legal 9..16.
REQ-007 Parameter VGA_BASE, 8'h90, VGA port IDs: HADDR=+0, LADDR=+1, COLOR=+2, READ=+3.
REQ-008 Parameter INT_CLR_ID, 8'hF0, port ID whose write clears pending interrupt.
REQ-009 CLK  in  1  single clock; all state on rising edge.
REQ-010 RESET  in  1  asynchronous, active-high reset.
REQ-011 IO_STRB  in  1  MCU I/O strobe; may stay high several CLK cycles.
REQ-012 PORT_ID  in  8  MCU port ID.
REQ-013 OUT_PORT  in  DATA_W  MCU write data.
REQ-014 IN_PORT  out  DATA_W  MCU read data.
REQ-015 IN_DATA  in  NUM_IN*DATA_W  input channels, channel k at bits [k*DATA_W +: DATA_W].
REQ-016 OUT_REGS  out  NUM_OUT*DATA_W  output registers, same packing.
REQ-017 VGA_WA  out  VGA_AW  framebuffer address; VGA_WD out DATA_W pixel data; VGA_WE out 1 write enable; VGA_RD in DATA_W read pixel.
REQ-018 INT_SRC  in  1  raw synchronous interrupt source; INT_R out 1 pending interrupt to MCU.

Function
REQ-019 Write event SHALL be detected once per IO_STRB rising edge (IO_STRB=1 and previous-cycle IO_STRB=0); a held strobe SHALL produce exactly one write.
REQ-020 On a write event to OUT_BASE+k (k<NUM_OUT), register k SHALL take OUT_PORT; visible on OUT_REGS the following cycle.
REQ-021 Write to HADDR SHALL load VGA_WA[VGA_AW-1:8] from OUT_PORT[VGA_AW-9:0]; LADDR SHALL load VGA_WA[7:0].
REQ-022 Write to COLOR SHALL load VGA_WD with OUT_PORT and assert VGA_WE for exactly one cycle, coincident with VGA_WD valid.
REQ-023 VGA_WE SHALL be 0 in all other cycles; VGA_WA SHALL be stable throughout a VGA_WE cycle.
REQ-024 IN_PORT SHALL be combinational: IN_DATA channel k when PORT_ID=IN_BASE+k (k<NUM_IN), VGA_RD when PORT_ID=VGA_BASE+3, {DATA_W-1 zeros, INT_R} when PORT_ID=INT_CLR_ID, else 0.
REQ-025 Port IDs outside every decoded range SHALL be ignored for writes and SHALL change no state.
REQ-026 INT_SRC rising edge (0 then 1 on consecutive cycles) SHALL set pending; INT_R SHALL equal pending.
REQ-027 Write event to INT_CLR_ID SHALL clear pending; simultaneous set and clear SHALL leave pending set.
REQ-028 Overlapping decode ranges SHALL resolve in priority: output registers, VGA, INT_CLR_ID.

Reset
REQ-029 RESET SHALL asynchronously force all OUT_REGS, VGA_WA, VGA_WD to 0, VGA_WE=0, INT_R=0, strobe and INT_SRC history to 0.
REQ-030 IO_STRB held high across RESET deassertion SHALL NOT produce a write event.
REQ-031 Reset asserted during a VGA_WE cycle SHALL drop VGA_WE immediately.

Configuration
REQ-032 Macro VGA_AUTOINC_EN defined: VGA_WA SHALL increment by 1 in the cycle after each VGA_WE pulse, wrapping 2^VGA_AW-1 to 0; a HADDR/LADDR write in that same cycle SHALL take precedence over the increment.
REQ-033 Macro VGA_AUTOINC_EN undefined: VGA_WA SHALL change only on HADDR/LADDR writes.

Verification
REQ-034 IO_STRB high 4 cycles, PORT_ID=8'h41, OUT_PORT=8'hA5 -> OUT_REGS[15:8]=8'hA5 after one cycle; exactly one write.
REQ-035 Writes HADDR=8'h1F, LADDR=8'hFF, COLOR=8'h3C -> VGA_WA=13'h1FFF, VGA_WD=8'h3C, VGA_WE high one cycle; with VGA_AUTOINC_EN VGA_WA then 13'h0000.
REQ-036 PORT_ID=8'h21, IN_DATA=16'h5A00 -> IN_PORT=8'h5A; PORT_ID=8'h93, VGA_RD=8'hE1 -> IN_PORT=8'hE1; PORT_ID=8'h77 -> 8'h00.
REQ-037 INT_SRC pulse -> INT_R=1; write to 8'hF0 -> INT_R=0; INT_SRC edge same cycle as clear -> INT_R stays 1.
REQ-038 RESET asserted mid-stream with VGA_WE=1 and OUT_REGS nonzero -> all outputs 0 without clock edge; IO_STRB held high through release -> no write.
